// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Definitions shared by the write arbiter, its round-robin picker and the
//   downstream demultiplexer that unpacks the FIFO word.
//   Contents:
//     clog2()          ceiling log2 used for tag and counter widths
//     arb_state_e      arbiter state encoding (IDLE=0, GRANT=1)
//     FIFO_DATA_LSB    payload position inside fifo_in
//     fifo_last_bit()  position of the last flag for a given payload width
//     fifo_id_lsb()    lowest bit of the source tag for a given payload width
package fifo_wr_arbiter_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // fifo_in is packed {grant_id, last_out, data}; the payload sits at bit 0.
  localparam int FIFO_DATA_LSB = 0;

  function automatic int fifo_last_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int fifo_id_lsb(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Scans the request vector upward
//   starting at ptr, wrapping from NUM_REQ-1 back to 0, and reports the first
//   asserted index. Also used by the read-side scheduler.
//   Ports:
//     req    in   NUM_REQ  request vector
//     ptr    in   IDX_W    scan start position (must be < NUM_REQ)
//     found  out  1        at least one request is asserted
//     index  out  IDX_W    first asserted index at or after ptr (0 if none)
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // The candidate index is computed as an integer and wrapped explicitly so
  // that non-power-of-two NUM_REQ never aliases onto a nonexistent requester.
  always_comb begin
    int   cand;
    logic hit;
    found = 1'b0;
    index = '0;
    cand  = 0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      hit = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (cand == j) begin
          hit = req[j];
        end
      end
      if (!found && hit) begin
        found = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   A producer owns the port for one packet or MAX_BURST beats, whichever
//   ends first. Every beat is tagged with its source ID and an end flag.
//   Ports:
//     clk          in   1                     rising-edge clock
//     rst_n        in   1                     asynchronous active-low reset
//     req_valid    in   NUM_REQ               beat available per producer
//     req_data     in   NUM_REQ*DATA_WIDTH    payloads, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_last     in   NUM_REQ               final beat of a packet
//     req_ready    out  NUM_REQ               beat accepted (one-hot or zero)
//     fifo_full    in   1                     FIFO full flag
//     fifo_wr_en   out  1                     FIFO write enable
//     fifo_in      out  ID_W+1+DATA_WIDTH     {grant_id, last_out, data}
//     grant_id     out  ID_W                  current owner, valid while busy
//     busy         out  1                     a grant is active
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [ID_W+DATA_WIDTH:0]      fifo_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W    = clog2(MAX_BURST + 1);
  localparam int LAST_BIT = fifo_last_bit(DATA_WIDTH);
  localparam int ID_LSB   = fifo_id_lsb(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e            state;
  arb_state_e            state_nxt;
  logic [ID_W-1:0]       gnt;
  logic [ID_W-1:0]       gnt_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       rr_ptr_nxt;
  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]      beat_cnt_nxt;

  logic                  pick_found;
  logic [ID_W-1:0]       pick_index;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  at_limit;
  logic                  last_out;
  logic                  xfer;
  logic                  release_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_index)
  );

  // Route the owner's valid/last/data through a compare-based mux so a
  // non-power-of-two NUM_REQ never indexes past the request vectors.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A forced split looks like a packet end to the consumer, so the limit
  // beat carries last_out just like a genuine last beat.
  assign at_limit      = (beat_cnt == CNT_LIMIT);
  assign last_out      = sel_last | at_limit;
  assign xfer          = (state == GRANT) & sel_valid & ~fifo_full;
  assign release_grant = xfer & last_out;

  // State register: owner, round-robin pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next state: IDLE only arbitrates; GRANT counts beats and hands the
  // pointer to the requester after the owner when the grant ends.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_nxt      = pick_index;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
        if (release_grant) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (gnt == LAST_ID) ? '0 : gnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs: ready depends only on ownership and full, never on valid.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    busy       = (state == GRANT);
    grant_id   = gnt;
    fifo_in    = '0;
    fifo_in[FIFO_DATA_LSB +: DATA_WIDTH] = sel_data;
    fifo_in[LAST_BIT]                    = last_out;
    fifo_in[ID_LSB +: ID_W]              = gnt;
    if (state == GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt == ID_W'(i)) begin
          req_ready[i] = ~fifo_full;
        end
      end
      fifo_wr_en = xfer;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=8).
//   A per-cycle vector table covers reset, a single packet, round robin and a
//   one-cycle full stall; hand sequences with producer queues and an expected
//   write list cover forced split, long full stall, bubble and async reset.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [10:0] fifo_in;
  logic [1:0]  grant_id;
  logic        busy;

  int tests_run;
  int failures;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic        exp_busy;
    logic [1:0]  exp_gid;
    logic        exp_wr;
    logic [10:0] exp_fin;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs[$];

  logic [8:0]  prod_mem [4][16];
  int          prod_head [4];
  int          prod_tail [4];
  logic [10:0] exp_q[$];

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_in    (fifo_in),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                        input logic [31:0] data, input logic full, input logic e_busy,
                        input logic [1:0] e_gid, input logic e_wr, input logic [10:0] e_fin,
                        input logic [3:0] e_ready);
    vec_t v;
    v.rst_n = rst; v.valid = valid; v.last = last; v.data = data; v.full = full;
    v.exp_busy = e_busy; v.exp_gid = e_gid; v.exp_wr = e_wr; v.exp_fin = e_fin;
    v.exp_ready = e_ready;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rst_n;
    req_valid = v.valid;
    req_last  = v.last;
    req_data  = v.data;
    fifo_full = v.full;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    checkEq($sformatf("row%0d_busy", row), 32'(busy), 32'(v.exp_busy));
    checkEq($sformatf("row%0d_wr_en", row), 32'(fifo_wr_en), 32'(v.exp_wr));
    checkEq($sformatf("row%0d_ready", row), 32'(req_ready), 32'(v.exp_ready));
    if (v.exp_busy || !v.rst_n) checkEq($sformatf("row%0d_grant_id", row), 32'(grant_id), 32'(v.exp_gid));
    if (v.exp_wr) checkEq($sformatf("row%0d_fifo_in", row), 32'(fifo_in), 32'(v.exp_fin));
  endtask

  task automatic buildTable();
    // reset, then producer 2 sends A1 A2 A3(last)
    addVec(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b0100, 4'b0000, 32'h00A10000, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b0100, 4'b0000, 32'h00A10000, 0, 1, 2, 1, 11'h4A1, 4'b0100);
    addVec(1, 4'b0100, 4'b0000, 32'h00A20000, 0, 1, 2, 1, 11'h4A2, 4'b0100);
    addVec(1, 4'b0100, 4'b0100, 32'h00A30000, 0, 1, 2, 1, 11'h5A3, 4'b0100);
    addVec(1, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 11'h000, 4'b0000);
    // all producers hold one-beat packets; rr_ptr=3 gives 3, then 0,1,2,3,0
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 3, 1, 11'h713, 4'b1000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 0, 1, 11'h110, 4'b0001);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 1, 1, 11'h311, 4'b0010);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 2, 1, 11'h512, 4'b0100);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 3, 1, 11'h713, 4'b1000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 0, 1, 11'h110, 4'b0001);
    // one-cycle full stall on producer 1's grant
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 0, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 1, 0, 11'h000, 4'b0000);
    addVec(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 1, 1, 11'h311, 4'b0010);
    addVec(1, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 11'h000, 4'b0000);
  endtask

  task automatic pushBeat(input int p, input logic [7:0] d, input logic l);
    if (prod_tail[p] < 16) begin
      prod_mem[p][prod_tail[p]] = {l, d};
      prod_tail[p]++;
    end
  endtask

  function automatic bit pending();
    bit any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (prod_head[i] < prod_tail[i]) any = 1'b1;
    end
    return any;
  endfunction

  task automatic clearProducers();
    for (int i = 0; i < 4; i++) begin
      prod_head[i] = 0;
      prod_tail[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic driveInputs(input logic full, input logic [3:0] bubble);
    for (int i = 0; i < 4; i++) begin
      if (prod_head[i] < prod_tail[i]) begin
        req_valid[i]       = ~bubble[i];
        req_last[i]        = prod_mem[i][prod_head[i]][8];
        req_data[i*8 +: 8] = prod_mem[i][prod_head[i]][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
    fifo_full = full;
  endtask

  // One clock of producer/FIFO modelling; entered and left at posedge+1.
  task automatic runCycle(input logic full, input logic [3:0] bubble,
                          output logic [3:0] rdy_seen, output logic wr_seen);
    logic [3:0] acc;
    driveInputs(full, bubble);
    #3;
    rdy_seen = req_ready;
    wr_seen  = fifo_wr_en;
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL unexpected_write: got fifo_in 0x%0h, expected no write", fifo_in);
      end else begin
        checkEq("scoreboard", 32'(fifo_in), 32'(exp_q.pop_front()));
      end
    end
    if (full) begin
      checkEq("full_wr_en", 32'(fifo_wr_en), 32'(0));
      checkEq("full_ready", 32'(req_ready), 32'(0));
    end
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) prod_head[i]++;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    logic [3:0] rdy;
    logic wr;
    n = 0;
    while ((exp_q.size() != 0 || pending()) && n < budget) begin
      runCycle(1'b0, 4'b0000, rdy, wr);
      n++;
    end
    checkEq({name, "_writes_left"}, 32'(exp_q.size()), 32'(0));
    checkEq({name, "_idle_after"}, 32'(busy), 32'(0));
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    clearProducers();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic seqSplit();
    doReset();
    for (int k = 0; k < 10; k++) pushBeat(1, 8'(8'h20 + k), (k == 9));
    pushBeat(3, 8'h30, 1'b1);
    for (int k = 0; k < 7; k++) exp_q.push_back(11'(11'h220 + k));
    exp_q.push_back(11'h327);
    exp_q.push_back(11'h730);
    exp_q.push_back(11'h228);
    exp_q.push_back(11'h329);
    drain("split", 60);
  endtask

  task automatic seqFull();
    logic [3:0] rdy;
    logic wr;
    doReset();
    pushBeat(0, 8'h40, 1'b0);
    pushBeat(0, 8'h41, 1'b0);
    pushBeat(0, 8'h42, 1'b0);
    pushBeat(0, 8'h43, 1'b1);
    exp_q.push_back(11'h040);
    exp_q.push_back(11'h041);
    exp_q.push_back(11'h042);
    exp_q.push_back(11'h143);
    repeat (3) runCycle(1'b0, 4'b0000, rdy, wr);
    for (int k = 0; k < 5; k++) begin
      checkEq("full_beat_cnt", 32'(dut.beat_cnt), 32'(2));
      checkEq("full_busy", 32'(busy), 32'(1));
      runCycle(1'b1, 4'b0000, rdy, wr);
    end
    checkEq("full_beat_cnt_after", 32'(dut.beat_cnt), 32'(2));
    runCycle(1'b0, 4'b0000, rdy, wr);
    checkEq("full_resume_wr", 32'(wr), 32'(1));
    drain("full", 20);
  endtask

  task automatic seqBubble();
    logic [3:0] rdy;
    logic wr;
    doReset();
    pushBeat(0, 8'h60, 1'b1);
    for (int k = 0; k < 4; k++) pushBeat(2, 8'(8'h50 + k), (k == 3));
    pushBeat(3, 8'h63, 1'b1);
    exp_q.push_back(11'h160);
    exp_q.push_back(11'h450);
    exp_q.push_back(11'h451);
    exp_q.push_back(11'h452);
    exp_q.push_back(11'h553);
    exp_q.push_back(11'h763);
    repeat (5) runCycle(1'b0, 4'b0000, rdy, wr);
    for (int k = 0; k < 3; k++) begin
      checkEq("bubble_busy", 32'(busy), 32'(1));
      checkEq("bubble_grant_id", 32'(grant_id), 32'(2));
      runCycle(1'b0, 4'b0100, rdy, wr);
      checkEq("bubble_ready", 32'(rdy), 32'(4'b0100));
      checkEq("bubble_wr_en", 32'(wr), 32'(0));
    end
    checkEq("bubble_hold_id", 32'(grant_id), 32'(2));
    drain("bubble", 20);
  endtask

  task automatic seqAsyncReset();
    logic [3:0] rdy;
    logic wr;
    doReset();
    for (int k = 0; k < 4; k++) pushBeat(1, 8'(8'h70 + k), (k == 3));
    exp_q.push_back(11'h270);
    repeat (2) runCycle(1'b0, 4'b0000, rdy, wr);
    driveInputs(1'b0, 4'b0000);
    #1;
    checkEq("arst_beat2_wr_en", 32'(fifo_wr_en), 32'(1));
    rst_n = 1'b0;
    #1;
    checkEq("arst_wr_en", 32'(fifo_wr_en), 32'(0));
    checkEq("arst_busy", 32'(busy), 32'(0));
    checkEq("arst_ready", 32'(req_ready), 32'(0));
    checkEq("arst_grant_id", 32'(grant_id), 32'(0));
    clearProducers();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushBeat(0, 8'h80, 1'b1);
    pushBeat(1, 8'h81, 1'b1);
    exp_q.push_back(11'h180);
    exp_q.push_back(11'h381);
    drain("arst", 20);
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    clearProducers();
    @(posedge clk);
    #1;
    buildTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #3;
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end
    seqSplit();
    seqFull();
    seqBubble();
    seqAsyncReset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port among `NUM_REQ` producers. Each producer presents beats on a valid/ready interface and marks packet ends. The arbiter grants one producer at a time for a burst and drives the FIFO `in`/`wr_en` pins. It never writes while the FIFO reports `full`, because the FIFO itself has no overflow guard. Every beat is tagged with its source ID and a last flag, so a downstream consumer can demultiplex.

## Interface
- `NUM_REQ`, 4: number of producers, 2..16.
- `DATA_WIDTH`, 8: payload width per beat.
- `MAX_BURST`, 8: maximum beats per grant, 1..256.
- `ID_W`, derived as clog2(NUM_REQ): width of the source tag.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  beat available, one bit per producer.
- `req_data`  in  NUM_REQ*DATA_WIDTH  payloads; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  beat is the final beat of its packet.
- `req_ready`  out  NUM_REQ  beat accepted this cycle; one-hot or zero.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_in`  out  ID_W+1+DATA_WIDTH  write word, packed as {grant_id, last_out, data}.
- `grant_id`  out  ID_W  current owner; valid only while `busy` is high.
- `busy`  out  1  a grant is active (state is GRANT).

## Operation
- The FSM has two states, IDLE and GRANT. The registered state is `state`, `gnt`, `rr_ptr` and `beat_cnt` (width clog2(MAX_BURST+1)).
- **IDLE:**
  - If any `req_valid` is high, select the first asserted index scanning upward from `rr_ptr` with wrap.
  - Register that index into `gnt`, clear `beat_cnt`, and go to GRANT.
  - No beat is accepted in IDLE.
- **GRANT:**
  - `xfer = req_valid[gnt] & ~fifo_full`.
  - `req_ready[gnt] = ~fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en = xfer`.
  - `fifo_in = {gnt, last_out, req_data[gnt]}`.
  - On each `xfer`, `beat_cnt` increments.
- **Release.** The grant releases on an `xfer` beat that meets either condition:
  - `req_last[gnt]` is high, or
  - `beat_cnt == MAX_BURST-1` (forced split).

  On release, `rr_ptr` ← (gnt+1) mod NUM_REQ and the FSM returns to IDLE.
- **last_out** = `req_last[gnt] | (beat_cnt == MAX_BURST-1)`. A forced split is therefore visible to the consumer as an end of fragment.
- **Bubbles.** If the owner drops `req_valid` mid-burst, the grant is held: no write, no timeout. Producers must not deassert valid indefinitely inside a packet.
- **FIFO full.** `fifo_full` high stalls the transfer. `fifo_wr_en` stays 0 and the owner's `req_ready` stays 0. State and counters hold.
- **Non-owners** see `req_ready` = 0 and are never starved: the worst-case wait is (NUM_REQ-1) × (MAX_BURST+1) transfer cycles plus full stalls.
- **Index arithmetic.** All index arithmetic is modulo NUM_REQ. A non-power-of-two NUM_REQ wraps explicitly from NUM_REQ-1 to 0.

## Timing
- **Reset values.** Asserting `rst_n` low immediately forces:
  - state = IDLE;
  - `gnt`, `rr_ptr`, `beat_cnt` = 0;
  - `busy` = 0, `grant_id` = 0;
  - `req_ready` = 0, `fifo_wr_en` = 0 (combinational from state).

  A reset mid-burst drops the partial packet: no further writes, no trailing last beat. Deassertion is synchronized externally.
- **Arbitration latency.** One cycle: valid seen in IDLE at cycle t gives the first possible write at t+1.
- **Throughput.** A burst of k beats occupies k+1 cycles including the IDLE arbitration cycle. Back-to-back packets from different producers are separated by one idle cycle.
- **FIFO timing.** `fifo_full` is combinational in the FIFO from its occupancy register, so gating within the same cycle is exact. The FIFO's usable capacity is DEPTH-1, and the arbiter relies only on `full`.
- **Combinational paths.** `req_ready`, `fifo_wr_en` and `fifo_in` are combinational from registered state plus `fifo_full`, `req_valid` and `req_data`. There is no combinational path from `req_valid` to `req_ready`.

## Structure
- **Shared package:** a clog2 function, the state encoding constants (IDLE=1'b0, GRANT=1'b1) and the `fifo_in` field offsets. The offsets are shared with the downstream demultiplexer.
- **Sub-module `rr_pick`:** combinational; inputs are the NUM_REQ request vector and `rr_ptr`; outputs are `found` and `index`. It is reused by the read-side scheduler.
- **Excluded:** the FIFO and the BRAM are not instantiated here. The top level connects `fifo_wr_en`/`fifo_in`/`fifo_full` to the FIFO's `wr_en`/`in`/`full`.

## Test plan
- **Reset and single packet:**
  - Stimulus: reset low, then high. Producer 2 sends 3 beats 0xA1, 0xA2, 0xA3, with last on 0xA3.
  - Required: `busy` rises one cycle after valid. Three consecutive writes `fifo_in` = {2,0,A1}, {2,0,A2}, {2,1,A3}. Then IDLE, `rr_ptr` = 3.
- **Round robin:**
  - Stimulus: all 4 producers hold 1-beat packets continuously, starting from `rr_ptr` = 0.
  - Required: grant order 0, 1, 2, 3, 0. One write every 2 cycles.
- **Forced split:**
  - Stimulus: producer 1 sends 10 beats with MAX_BURST=8 while producer 3 is waiting.
  - Required: 8 beats, the 8th with last_out=1, then producer 3's packet, then producer 1's remaining 2 beats.
- **FIFO full:**
  - Stimulus: `fifo_full` held high for 5 cycles mid-burst.
  - Required: `fifo_wr_en` = 0 and `req_ready` = 0 throughout. `beat_cnt` unchanged. Resumes on the next cycle with no lost or duplicated beat. Scoreboard against the FIFO model.
- **Bubble:**
  - Stimulus: the owner drops valid for 3 cycles mid-packet while other producers are valid.
  - Required: the grant is held and no other producer is granted.
- **Async reset mid-burst:**
  - Stimulus: `rst_n` low between clock edges during beat 2.
  - Required: `fifo_wr_en` and `busy` go to 0 before the next edge. After release, a new packet from producer 0 is granted first.
